rr_src_arbiter: RTL
===================

Name: rr_src_arbiter

Overview:
- Two-source round-robin arbiter that sits directly upstream of the 2:1 select mux (twotoonemux).
- Drives that mux's select with a registered sel output.
- Forwards the granted source's data through a one-entry output register with valid/ready handshakes.
- Arbitration is burst-fair: a source keeps the grant for up to BURST consecutive beats while the other source waits.

Parameters:
- WIDTH, 8: data width of each source and of the output.
- BURST, 4: max consecutive beats granted to one source while the other is requesting; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  source A has a beat.
- a_data  input  WIDTH  source A payload.
- a_ready  output  1  source A beat accepted this cycle.
- b_valid  input  1  source B has a beat.
- b_data  input  WIDTH  source B payload.
- b_ready  output  1  source B beat accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered payload.
- out_ready  input  1  downstream takes the beat.
- sel  output  1  registered source of out_data (0=A, 1=B); wired to the downstream mux select.

Behaviour:
- Reset is asynchronous, active-low, single clock.
  - Reset values: out_valid=0, out_data=0, sel=0, owner=A, burst_cnt=0, state=EMPTY.
  - a_ready and b_ready are forced 0 while rst_n=0.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- Load condition: load = (state==EMPTY) | out_ready. Registered path only; no combinational valid-to-valid path.
- Grant is combinational, evaluated each cycle when load=1:
  - Only A valid: grant A. Only B valid: grant B. Neither valid: no grant.
  - Both valid and burst_cnt < BURST: grant the current owner.
  - Both valid and burst_cnt >= BURST: grant the other source.
- Handshake: a_ready = load & grant==A; b_ready = load & grant==B. At most one ready is high per cycle.
- On an accepted beat:
  - out_data <= granted data, sel <= granted source, out_valid <= 1.
  - If the granted source equals owner, burst_cnt <= burst_cnt+1, saturating at BURST.
  - Otherwise owner <= granted source and burst_cnt <= 1.
- Load with no grant: out_valid <= 0 and the state goes to EMPTY. out_data and sel hold their last values.
- FULL with out_ready=0: everything holds, both readies are 0, and the sources stall. Sources must hold valid and data stable until ready.
- Latency: a beat accepted in cycle N appears on out_valid/out_data in N+1. Throughput is 1 beat per cycle when out_ready stays high.
- Idle cycles (neither valid) do not reset burst_cnt or owner.
- burst_cnt width is 4 bits, sufficient for BURST<=15.
- Reset asserted mid-transfer drops the held beat immediately; no beat is replayed after reset releases.

Decomposition:
- Shared package/include holds:
  - the state encodings, EMPTY=1'b0 and FULL=1'b1;
  - the source encodings, SRC_A=1'b0 and SRC_B=1'b1.
- One sub-module is natural: rr_grant_logic, a purely combinational block.
  - Inputs: a_valid, b_valid, owner, burst_cnt, load.
  - Outputs: grant_valid, grant_src.
- The top level holds the output register, owner, burst_cnt and the state.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, sel=0 and both readies 0 in the same cycle. First beat after release is from A when both are valid.
- Solo source: A sends 0x11, 0x22, 0x33 with out_ready=1 and B idle -> outputs 0x11/0x22/0x33 on consecutive cycles, each one cycle after accept, with sel=0 throughout.
- Burst fairness, BURST=4: both sources continuously valid, A=0xA0+n and B=0xB0+n -> output order A0 A1 A2 A3 B0 B1 B2 B3 A4. sel toggles every 4 beats.
- Backpressure: out_ready=0 for 3 cycles while FULL holding 0x5C -> out_data stays 0x5C, a_ready=b_ready=0. Resumes with no beat lost or duplicated.
- Gap behaviour: A valid for 2 beats, 1 idle cycle, both valid -> A is granted 2 more beats (total 4) before B. During the idle cycle out_valid=0.
- Switch when owner drops: owner A after 2 beats, then A drops while B is valid -> B is granted immediately with burst_cnt=1 and sel=1 on the next cycle.

Source files
------------

// File: rtl/rr_src_arbiter_pkg.sv
// rr_src_arbiter_pkg: state and source encodings shared by the arbiter blocks
package rr_src_arbiter_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/rr_src_arbiter_grant.sv
// rr_grant_logic: combinational burst-fair grant between sources A and B
module rr_grant_logic
  import rr_src_arbiter_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic       a_valid,
  input  logic       b_valid,
  input  logic       owner,
  input  logic [3:0] burst_cnt,
  input  logic       load,
  output logic       grant_valid,
  output logic       grant_src
);
  logic both;
  assign both = a_valid & b_valid;
  assign grant_valid = load & (a_valid | b_valid);
  // under contention the owner keeps the grant until its burst budget is spent
  assign grant_src = both ? ((burst_cnt < 4'(BURST)) ? owner : ~owner) : (b_valid ? SRC_B : SRC_A);
endmodule

// File: rtl/rr_src_arbiter.sv
// rr_src_arbiter: two-source burst-fair round-robin arbiter with a registered output stage
module rr_src_arbiter
  import rr_src_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);
  state_t state, state_next;
  logic owner, load, grant_valid, grant_src;
  logic [3:0] burst_cnt;
  assign load = (state == EMPTY) | out_ready;
  rr_grant_logic #(.BURST(BURST)) u_grant (
    .a_valid(a_valid),
    .b_valid(b_valid),
    .owner(owner),
    .burst_cnt(burst_cnt),
    .load(load),
    .grant_valid(grant_valid),
    .grant_src(grant_src)
  );
  assign a_ready = rst_n & grant_valid & (grant_src == SRC_A);
  assign b_ready = rst_n & grant_valid & (grant_src == SRC_B);
  assign out_valid = state == FULL;
  always_comb state_next = load ? (grant_valid ? FULL : EMPTY) : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      sel       <= SRC_A;
      owner     <= SRC_A;
      burst_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant_valid) begin
        out_data <= (grant_src == SRC_B) ? b_data : a_data;
        sel      <= grant_src;
        if (grant_src == owner) begin
          burst_cnt <= (burst_cnt >= 4'(BURST)) ? 4'(BURST) : burst_cnt + 4'd1;
        end else begin
          owner     <= grant_src;
          burst_cnt <= 4'd1;
        end
      end
    end
  end
endmodule
